// File: rtl/seq_pattern_gen.sv
// Bit-serial pattern generator: shifts a latched pattern out MSB-first, repeated
// a programmed number of times with optional zero gaps between repetitions.
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    state_t             state_r, state_s;
    logic [PAT_W-1:0]   pat_r, pat_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [LEN_W-1:0]   idx_r, idx_s;
    logic [REP_W-1:0]   rep_r, rep_s;
    logic [GAP_W-1:0]   gap_len_r, gap_len_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               dout_r, dout_s;
    logic               dvalid_r, dvalid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [LEN_W-1:0]   eff_len_s;

    // Select pattern bit i without an index wider than the pattern's address range.
    function automatic logic pick_bit(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic b;
        b = 1'b0;
        for (int k = 0; k < PAT_W; k++) begin
            b = b | (p[k] & (LEN_W'(k) == i));
        end
        return b;
    endfunction

    // Requested length clamped to the pattern width.
    always_comb begin
        if (len > LEN_W'(PAT_W)) begin
            eff_len_s = LEN_W'(PAT_W);
        end else begin
            eff_len_s = len;
        end
    end

    // Next-state and next-output logic; each output register holds the value for the
    // cycle that follows the edge, so the state names what is on dout right now.
    always_comb begin
        state_s   = state_r;
        pat_s     = pat_r;
        len_s     = len_r;
        idx_s     = idx_r;
        rep_s     = rep_r;
        gap_len_s = gap_len_r;
        gap_s     = gap_r;
        dout_s    = 1'b0;
        dvalid_s  = 1'b0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((eff_len_s != {LEN_W{1'b0}}) && (reps != {REP_W{1'b0}})) begin
                        state_s   = ST_SHIFT;
                        pat_s     = pattern;
                        len_s     = eff_len_s;
                        idx_s     = eff_len_s - LEN_W'(1);
                        rep_s     = reps - REP_W'(1);
                        gap_len_s = gap;
                        gap_s     = {GAP_W{1'b0}};
                        dout_s    = pick_bit(pattern, eff_len_s - LEN_W'(1));
                        dvalid_s  = 1'b1;
                        busy_s    = 1'b1;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (idx_r != {LEN_W{1'b0}}) begin
                    idx_s    = idx_r - LEN_W'(1);
                    dout_s   = pick_bit(pat_r, idx_r - LEN_W'(1));
                    dvalid_s = 1'b1;
                    busy_s   = 1'b1;
                end else if (rep_r != {REP_W{1'b0}}) begin
                    rep_s  = rep_r - REP_W'(1);
                    busy_s = 1'b1;
                    if (gap_len_r != {GAP_W{1'b0}}) begin
                        state_s = ST_GAP;
                        gap_s   = gap_len_r - GAP_W'(1);
                    end else begin
                        idx_s    = len_r - LEN_W'(1);
                        dout_s   = pick_bit(pat_r, len_r - LEN_W'(1));
                        dvalid_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end
            end
            ST_GAP: begin
                busy_s = 1'b1;
                if (gap_r != {GAP_W{1'b0}}) begin
                    gap_s = gap_r - GAP_W'(1);
                end else begin
                    state_s  = ST_SHIFT;
                    idx_s    = len_r - LEN_W'(1);
                    dout_s   = pick_bit(pat_r, len_r - LEN_W'(1));
                    dvalid_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            pat_r     <= {PAT_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            idx_r     <= {LEN_W{1'b0}};
            rep_r     <= {REP_W{1'b0}};
            gap_len_r <= {GAP_W{1'b0}};
            gap_r     <= {GAP_W{1'b0}};
            dout_r    <= 1'b0;
            dvalid_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pat_r     <= pat_s;
            len_r     <= len_s;
            idx_r     <= idx_s;
            rep_r     <= rep_s;
            gap_len_r <= gap_len_s;
            gap_r     <= gap_s;
            dout_r    <= dout_s;
            dvalid_r  <= dvalid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign dout   = dout_r;
    assign dvalid = dvalid_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: directed cases plus random transfers
// compared cycle by cycle against a queue-based model of the serial stream.
module tb_seq_pattern_gen;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             dout, dvalid, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_q[$];   // {dout, dvalid, busy} per transfer cycle

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .reps(reps), .gap(gap), .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected stream: reps copies of the clamped pattern MSB-first, gap zeros between.
    task automatic build(input logic [PAT_W-1:0] p, input int l, input int r, input int g);
        int eff;
        exp_q.delete();
        eff = (l > PAT_W) ? PAT_W : l;
        if (eff == 0) r = 0;
        for (int k = 0; k < r; k++) begin
            for (int b = eff - 1; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1});
            if (k < r - 1) for (int j = 0; j < g; j++) exp_q.push_back(3'b001);
        end
    endtask

    task automatic apply(input logic [PAT_W-1:0] p, input int l, input int r, input int g);
        pattern = p;
        len     = LEN_W'(l);
        reps    = REP_W'(r);
        gap     = GAP_W'(g);
        start   = 1'b1;
    endtask

    // Call at a negedge after apply(); returns positioned at the done negedge.
    task automatic run(input string tag, input logic [PAT_W-1:0] p, input int l,
                       input int r, input int g, input int poke);
        build(p, l, r, g);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            check({tag, ".dout"},   dout,   exp_q[k][2]);
            check({tag, ".dvalid"}, dvalid, exp_q[k][1]);
            check({tag, ".busy"},   busy,   exp_q[k][0]);
            check({tag, ".done_lo"}, done,  1'b0);
            if (k == poke) begin
                start   = 1'b1;
                pattern = ~p;
                len     = LEN_W'($urandom_range(1, 8));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done"},      done,   1'b1);
        check({tag, ".done_busy"}, busy,   1'b0);
        check({tag, ".done_dv"},   dvalid, 1'b0);
        check({tag, ".done_dout"}, dout,   1'b0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, ".idle_done"}, done, 1'b0);
        check({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [PAT_W-1:0] rp;
        int rl, rr, rg;

        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0; gap = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.dout", dout, 1'b0);
        check("rst.dvalid", dvalid, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic transfer
        apply(8'b1011_0111, 8, 1, 0);
        run("basic", 8'b1011_0111, 8, 1, 0, -1);
        idle_check("basic");

        // Repetitions with gap
        apply(8'b0000_0111, 3, 2, 2);
        run("gap", 8'b0000_0111, 3, 2, 2, -1);
        idle_check("gap");

        // Back-to-back repetitions, then restart in the done cycle
        apply(8'b0000_0010, 2, 3, 0);
        run("b2b", 8'b0000_0010, 2, 3, 0, -1);
        apply(8'b0000_0001, 2, 2, 1);
        run("restart", 8'b0000_0001, 2, 2, 1, -1);
        idle_check("restart");

        // Degenerate and clamp cases
        apply(8'hA5, 0, 3, 1);
        run("len0", 8'hA5, 0, 3, 1, -1);
        idle_check("len0");
        apply(8'hA5, 5, 0, 1);
        run("reps0", 8'hA5, 5, 0, 1, -1);
        idle_check("reps0");
        apply(8'b1100_1010, 12, 2, 1);
        run("clamp", 8'b1100_1010, 12, 2, 1, -1);
        idle_check("clamp");

        // Start while busy is ignored
        apply(8'b1001_1101, 8, 2, 1);
        run("ignore", 8'b1001_1101, 8, 2, 1, 3);
        idle_check("ignore");

        // Reset during the 4th bit aborts with no done pulse
        apply(8'b1110_0101, 8, 2, 0);
        build(8'b1110_0101, 8, 2, 0);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort.dout", dout, exp_q[k][2]);
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort.dout0", dout, 1'b0);
        check("abort.dvalid0", dvalid, 1'b0);
        check("abort.busy0", busy, 1'b0);
        check("abort.done0", done, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) idle_check("abort");

        // Random transfers, some chained in the done cycle
        @(negedge clk);
        for (int t = 0; t < 24; t++) begin
            rp = PAT_W'($urandom);
            rl = $urandom_range(0, 12);
            rr = $urandom_range(0, 4);
            rg = $urandom_range(0, 3);
            apply(rp, rl, rr, rg);
            run("rand", rp, rl, rr, rg, -1);
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end
        idle_check("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Bit-serial pattern generator. It is the transmit-side counterpart of the team's serial sequence detectors. It loads a programmable bit pattern, shifts it out MSB-first one bit per clock, and repeats it a programmed number of times with an optional run of zero bits between repetitions. It sits upstream of a detector, either in a test harness or in a link, and drives the detector's `din` directly.

## Interface
Parameters:
- `PAT_W`, default 8: maximum pattern length in bits.
- `LEN_W`, default 4: width of `len`. Must satisfy 2^LEN_W > PAT_W.
- `REP_W`, default 4: width of `reps`.
- `GAP_W`, default 4: width of `gap`.

Ports:
- `clk`: input, 1 bit. Clock, rising edge.
- `rst`: input, 1 bit. Reset, synchronous, active-high.
- `start`: input, 1 bit. Request a transfer. Sampled only when `busy`=0.
- `pattern`: input, PAT_W bits. Pattern word. Bits `[len-1:0]` are sent, `pattern[len-1]` first.
- `len`: input, LEN_W bits. Number of pattern bits to send.
- `reps`: input, REP_W bits. Number of pattern repetitions.
- `gap`: input, GAP_W bits. Number of zero cycles inserted between repetitions.
- `dout`: output, 1 bit. Serial data. Connects to a detector's `din`.
- `dvalid`: output, 1 bit. High during pattern-bit cycles only.
- `busy`: output, 1 bit. High while a transfer is in progress.
- `done`: output, 1 bit. One-cycle pulse when a transfer completes.

## Operation
- States: IDLE, SHIFT, GAP. Any illegal state encoding returns to IDLE with all outputs 0.
- IDLE, with `start`=1 at an edge:
  - Latch `pattern`, `eff_len`, `reps` and `gap` into internal registers.
  - Go to SHIFT. Inputs are ignored for the rest of the transfer.
- IDLE, with `start`=1 but `eff_len`=0 or `reps`=0:
  - No data is sent and the state stays IDLE.
  - `done` pulses in the next cycle and `busy` stays 0.
- Length rule: `eff_len` = min(`len`, PAT_W).
- SHIFT:
  - `dout` = current bit and `dvalid`=1.
  - The bit index decrements from `eff_len`-1 to 0.
- At the last bit of a repetition:
  - If repetitions remain and gap>0: go to GAP.
  - If repetitions remain and gap=0: stay in SHIFT and reload the bit index, so the next repetition's first bit follows back-to-back.
  - If it was the final repetition: go to IDLE.
- GAP:
  - `dout`=0 and `dvalid`=0 for exactly `gap` cycles, then return to SHIFT.
- `busy`=1 in every SHIFT and GAP cycle, and 0 otherwise.
- `done`=1 for exactly one cycle: the first IDLE cycle after the final bit.
- `start` is accepted in the same cycle `done` is high. The next transfer's first bit then appears in the following cycle, with no dead cycle between transfers beyond the `done` cycle.
- `start` is ignored while `busy`=1.
- Counters:
  - Repetition counter REP_W bits, bit index LEN_W bits, gap counter GAP_W bits.
  - All counters count down. None of them wrap, because terminal counts are detected before decrementing from 0.

## Timing
- All outputs are registered. Reset values: `dout`=0, `dvalid`=0, `busy`=0, `done`=0, state IDLE.
- Reset takes priority over every other input. A reset mid-transfer aborts it: all outputs are 0 in the cycle after the reset edge, and no `done` pulse is produced.
- Latency: with `start` sampled at edge E0, the first bit is on `dout` during cycle E0→E1.
- Transfer length is L = reps·eff_len + (reps−1)·gap cycles, all with `busy`=1.
- `done` is high in cycle L+1 counted from E0.
- Throughput: one bit per clock. Inter-transfer overhead is exactly 1 cycle (the `done`/IDLE cycle).

## Test plan
- **Basic transfer.** `pattern`=8'b1011_0111, `len`=8, `reps`=1, `gap`=0, `start` pulsed. Required: `dout`=1,0,1,1,0,1,1,1 over 8 cycles with `dvalid`=1, `busy`=1 for 8 cycles, `done` on the 9th cycle.
- **Repetitions with gap.** `pattern`=3'b111, `len`=3, `reps`=2, `gap`=2. Required: `dout`=1,1,1,0,0,1,1,1, with `dvalid`=1,1,1,0,0,1,1,1, then `done`. Feeding this into a 111 overlapping detector gives 2 detection pulses.
- **Back-to-back and restart.** `len`=2, `pattern`=2'b10, `reps`=3, `gap`=0. Required: `dout`=1,0,1,0,1,0 contiguous. A `start` issued in the `done` cycle produces the next first bit in the following cycle.
- **Degenerate and clamp cases.**
  - `len`=0 or `reps`=0: `done` pulses one cycle after `start`, with `busy` and `dvalid` never high.
  - `len`=12 with PAT_W=8: 8 bits are sent.
- **Reset and ignored start.**
  - `rst` asserted during the 4th bit: all outputs are 0 the next cycle and no `done` pulse.
  - `start` pulsed while `busy` with a different `pattern`: the current transfer is unchanged.
